// File: rtl/delay_latency_probe_if.sv
// Handshake/bus bundle between the latency probe and whoever drives it.
// The master side supplies start/probe/expected and the pipeline output;
// the slave side (the probe) drives the pipeline input and the results.
interface delay_latency_probe_if #(
  parameter int W     = 3,
  parameter int CNT_W = 5
);
  logic             start;
  logic [W-1:0]     probe_val;
  logic [CNT_W-1:0] expected;
  logic [W-1:0]     pipe_in;
  logic [W-1:0]     pipe_out;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] latency;
  logic             timeout;
  logic             match;

  modport master (
    output start, probe_val, expected, pipe_out,
    input  pipe_in, busy, done, latency, timeout, match
  );

  modport slave (
    input  start, probe_val, expected, pipe_out,
    output pipe_in, busy, done, latency, timeout, match
  );
endinterface

// File: rtl/delay_latency_probe.sv
// Latency probe for N-stage delay pipelines: flushes the pipeline with zeros,
// injects one nonzero probe word, counts cycles until it reappears at the
// pipeline output and reports latency, timeout and match against the
// expected depth. Every output is a register loaded from next-state logic,
// so nothing at the outputs depends combinationally on the inputs.
module delay_latency_probe #(
  parameter int W       = 3,
  parameter int CNT_W   = 5,
  parameter int MAX_LAT = 15
) (
  input logic                  clk,
  input logic                  reset,
  delay_latency_probe_if.slave bus
);

  localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(MAX_LAT);
  localparam logic [CNT_W-1:0] LP_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FLUSH = 3'd1,
    S_SEND  = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [W-1:0]     r_probe;
  logic [W-1:0]     w_probe_next;
  logic [CNT_W-1:0] r_exp;
  logic [CNT_W-1:0] w_exp_next;
  logic [W-1:0]     r_pipe_in;
  logic [W-1:0]     w_pipe_in_next;
  logic             r_busy;
  logic             w_busy_next;
  logic             r_done;
  logic             w_done_next;
  logic [CNT_W-1:0] r_latency;
  logic [CNT_W-1:0] w_latency_next;
  logic             r_timeout;
  logic             w_timeout_next;
  logic             r_match;
  logic             w_match_next;

  // Probe word seen at the pipeline output in the current cycle.
  logic             w_hit;
  // A start is only meaningful with a nonzero probe; zero cannot be told
  // apart from the flushed pipeline contents.
  logic             w_start_ok;

  assign w_hit      = (bus.pipe_out == r_probe);
  assign w_start_ok = bus.start && (bus.probe_val != '0);

  // Next-state, counter and result logic; every target defaults to hold.
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_probe_next   = r_probe;
    w_exp_next     = r_exp;
    w_latency_next = r_latency;
    w_timeout_next = r_timeout;
    w_match_next   = r_match;

    case (r_state)
      S_IDLE: begin
        if (w_start_ok) begin
          w_probe_next   = bus.probe_val;
          w_exp_next     = bus.expected;
          w_latency_next = '0;
          w_timeout_next = 1'b0;
          w_match_next   = 1'b0;
          w_cnt_next     = '0;
          w_state_next   = S_FLUSH;
        end
      end

      S_FLUSH: begin
        // MAX_LAT+1 zero cycles clear any pipeline up to that depth.
        if (r_cnt == LP_MAX) begin
          w_cnt_next   = '0;
          w_state_next = S_SEND;
        end else begin
          w_cnt_next = r_cnt + LP_ONE;
        end
      end

      S_SEND: begin
        // A hit here means pipe_out is a direct wire from pipe_in.
        if (w_hit) begin
          w_latency_next = '0;
          w_timeout_next = 1'b0;
          w_match_next   = (r_exp == '0);
          w_state_next   = S_DONE;
        end else begin
          w_cnt_next   = LP_ONE;
          w_state_next = S_WAIT;
        end
      end

      S_WAIT: begin
        if (w_hit) begin
          w_latency_next = r_cnt;
          w_timeout_next = 1'b0;
          w_match_next   = (r_cnt == r_exp);
          w_state_next   = S_DONE;
        end else if (r_cnt == LP_MAX) begin
          // Counter stops here; it never wraps past MAX_LAT.
          w_latency_next = LP_MAX;
          w_timeout_next = 1'b1;
          w_match_next   = 1'b0;
          w_state_next   = S_DONE;
        end else begin
          w_cnt_next = r_cnt + LP_ONE;
        end
      end

      S_DONE: begin
        w_state_next = S_IDLE;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Registered outputs are derived from the state being entered so that
  // pipe_in carries the probe exactly during the SEND cycle.
  always_comb begin
    w_pipe_in_next = '0;
    w_busy_next    = (w_state_next != S_IDLE);
    w_done_next    = (w_state_next == S_DONE);
    if (w_state_next == S_SEND) begin
      w_pipe_in_next = r_probe;
    end
  end

  // State and result registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_probe   <= '0;
      r_exp     <= '0;
      r_pipe_in <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_latency <= '0;
      r_timeout <= 1'b0;
      r_match   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_probe   <= w_probe_next;
      r_exp     <= w_exp_next;
      r_pipe_in <= w_pipe_in_next;
      r_busy    <= w_busy_next;
      r_done    <= w_done_next;
      r_latency <= w_latency_next;
      r_timeout <= w_timeout_next;
      r_match   <= w_match_next;
    end
  end

  assign bus.pipe_in = r_pipe_in;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.latency = r_latency;
  assign bus.timeout = r_timeout;
  assign bus.match   = r_match;

endmodule

// File: tb/tb_delay_latency_probe.sv
// Bench for delay_latency_probe: a configurable DFF chain / wire / tied-zero
// pipeline model, a table of hand-derived vectors, hand-written sequences
// for restart-while-busy, zero probe and mid-run reset, and a randomized
// loop checked against a latency model built from the stated timing rules.
module tb_delay_latency_probe;

  localparam int W       = 3;
  localparam int CNT_W   = 5;
  localparam int MAX_LAT = 15;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  delay_latency_probe_if #(.W(W), .CNT_W(CNT_W)) bus ();

  delay_latency_probe #(.W(W), .CNT_W(CNT_W), .MAX_LAT(MAX_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Pipeline under test: depth 0 = wire, depth N = N DFF stages.
  int       cfg_depth = 3;
  bit       cfg_tie0  = 1'b0;
  logic [W-1:0] chain [0:31];

  always @(posedge clk) begin
    chain[0] <= bus.pipe_in;
    for (int i = 1; i < 32; i++) chain[i] <= chain[i-1];
  end

  assign bus.pipe_out = cfg_tie0 ? '0 :
                        (cfg_depth == 0 ? bus.pipe_in : chain[cfg_depth-1]);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Reference: the probe shows up D cycles after SEND for a D-stage chain;
  // anything beyond MAX_LAT (or never) is a timeout reported as MAX_LAT.
  // done is seen 1 (start) + MAX_LAT+1 (flush) + 1 (send) + L cycles on.
  function automatic void model(input int depth, input bit tie0, input int exp_v,
                                output int cyc, output int lat, output int to,
                                output int mt);
    if (tie0 || depth > MAX_LAT) begin
      to  = 1;
      lat = MAX_LAT;
    end else begin
      to  = 0;
      lat = depth;
    end
    mt  = (to == 0 && lat == exp_v) ? 1 : 0;
    cyc = 1 + (MAX_LAT + 1) + 1 + lat;
  endfunction

  typedef struct {
    int depth;
    bit tie0;
    int probe;
    int exp_v;
    int cyc;
    int lat;
    int to;
    int mt;
    int mid_n;
  } vec_t;

  vec_t vecs [7];

  // One measurement: start, watch every cycle, then check the result.
  task automatic run_vec(input string name, input int depth, input bit tie0,
                         input int probe, input int exp_v, input int cyc,
                         input int lat, input int to, input int mt,
                         input int mid_n);
    int n, done_n, done_cnt, pin_nz, pin_val, pin_n, flush_bad, busy_low;
    int c_lat, c_to, c_mt;
    cfg_depth = depth;
    cfg_tie0  = tie0;
    @(posedge clk); #1;
    bus.start     = 1'b1;
    bus.probe_val = W'(probe);
    bus.expected  = CNT_W'(exp_v);
    n = 0; done_n = -1; done_cnt = 0; pin_nz = 0; pin_val = 0; pin_n = -1;
    flush_bad = 0; busy_low = 0; c_lat = -1; c_to = -1; c_mt = -1;
    while (n < 80 && !(done_n >= 0 && n >= done_n + 2)) begin
      @(posedge clk); #1;
      n++;
      if (n == mid_n) begin
        bus.start     = 1'b1;
        bus.probe_val = 3'd3;
        bus.expected  = '0;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.pipe_in != '0) begin
        pin_nz++;
        pin_val = int'(bus.pipe_in);
        pin_n   = n;
        if (n <= MAX_LAT + 1) flush_bad++;
      end
      if (done_n < 0 && !bus.busy) busy_low++;
      if (bus.done) begin
        done_cnt++;
        if (done_n < 0) begin
          done_n = n;
          c_lat  = int'(bus.latency);
          c_to   = int'(bus.timeout);
          c_mt   = int'(bus.match);
        end
      end
    end
    $display("[TB] %s: depth=%0d tie0=%0d probe=%0d exp=%0d -> done@%0d latency=%0d timeout=%0d match=%0d",
             name, depth, tie0, probe, exp_v, done_n, c_lat, c_to, c_mt);
    chk({name, " done_cycle"}, done_n, cyc);
    chk({name, " done_pulses"}, done_cnt, 1);
    chk({name, " latency"}, c_lat, lat);
    chk({name, " timeout"}, c_to, to);
    chk({name, " match"}, c_mt, mt);
    chk({name, " busy_gap"}, busy_low, 0);
    chk({name, " busy_after"}, int'(bus.busy), 0);
    chk({name, " latency_held"}, int'(bus.latency), lat);
    chk({name, " match_held"}, int'(bus.match), mt);
    chk({name, " probe_cycles"}, pin_nz, 1);
    chk({name, " probe_word"}, pin_val, probe);
    chk({name, " probe_at"}, pin_n, MAX_LAT + 2);
    chk({name, " flush_nonzero"}, flush_bad, 0);
  endtask

  // Start with a zero probe must be ignored entirely.
  task automatic zero_start(input int prev_lat);
    int busy_seen, done_seen;
    busy_seen = 0; done_seen = 0;
    @(posedge clk); #1;
    bus.start     = 1'b1;
    bus.probe_val = '0;
    bus.expected  = CNT_W'(1);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.busy) busy_seen++;
      if (bus.done) done_seen++;
    end
    $display("[TB] zero_probe: busy_seen=%0d done_seen=%0d latency=%0d",
             busy_seen, done_seen, bus.latency);
    chk("zero_probe busy", busy_seen, 0);
    chk("zero_probe done", done_seen, 0);
    chk("zero_probe latency_held", int'(bus.latency), prev_lat);
  endtask

  initial begin
    int done_seen, last_lat;
    int depth, probe, exp_v, cyc, lat, to, mt;
    bit tie0;

    bus.start     = 1'b0;
    bus.probe_val = '0;
    bus.expected  = '0;

    //               depth tie0 probe exp cyc lat to mt mid
    vecs[0] = '{3,  1'b0, 5, 3,  21, 3,  0, 1, -1};
    vecs[1] = '{3,  1'b0, 5, 2,  21, 3,  0, 0, -1};
    vecs[2] = '{0,  1'b0, 7, 0,  18, 0,  0, 1, -1};
    vecs[3] = '{0,  1'b1, 1, 0,  33, 15, 1, 0, -1};
    vecs[4] = '{15, 1'b0, 2, 15, 33, 15, 0, 1, -1};
    vecs[5] = '{16, 1'b0, 4, 15, 33, 15, 1, 0, -1};
    vecs[6] = '{10, 1'b0, 5, 10, 28, 10, 0, 1, 20};

    repeat (3) @(posedge clk);
    #1;
    chk("reset pipe_in", int'(bus.pipe_in), 0);
    chk("reset busy", int'(bus.busy), 0);
    chk("reset done", int'(bus.done), 0);
    chk("reset latency", int'(bus.latency), 0);
    chk("reset timeout", int'(bus.timeout), 0);
    chk("reset match", int'(bus.match), 0);
    reset = 1'b1;

    for (int v = 0; v < 7; v++) begin
      run_vec($sformatf("vec%0d", v), vecs[v].depth, vecs[v].tie0, vecs[v].probe,
              vecs[v].exp_v, vecs[v].cyc, vecs[v].lat, vecs[v].to, vecs[v].mt,
              vecs[v].mid_n);
    end

    zero_start(vecs[6].lat);

    // Reset during WAIT: aborts at once, no done, then a clean new run.
    cfg_depth = 8;
    cfg_tie0  = 1'b0;
    @(posedge clk); #1;
    bus.start     = 1'b1;
    bus.probe_val = 3'd6;
    bus.expected  = CNT_W'(8);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    chk("pre_abort busy", int'(bus.busy), 1);
    #2;
    reset = 1'b0;
    #1;
    chk("abort pipe_in", int'(bus.pipe_in), 0);
    chk("abort busy", int'(bus.busy), 0);
    chk("abort done", int'(bus.done), 0);
    chk("abort latency", int'(bus.latency), 0);
    chk("abort timeout", int'(bus.timeout), 0);
    chk("abort match", int'(bus.match), 0);
    done_seen = 0;
    cfg_depth = 3;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (bus.done) done_seen++;
    end
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) done_seen++;
    end
    chk("abort no_done", done_seen, 0);
    $display("[TB] reset_abort: outputs cleared, done_seen=%0d", done_seen);
    run_vec("after_reset", 3, 1'b0, 6, 3, 21, 3, 0, 1, -1);
    last_lat = 3;

    // Randomized runs against the latency model.
    for (int r = 0; r < 30; r++) begin
      depth = int'($urandom_range(0, 16));
      tie0  = ($urandom_range(0, 5) == 0);
      probe = int'($urandom_range(0, 7));
      exp_v = int'($urandom_range(0, 17));
      if (probe == 0) begin
        zero_start(last_lat);
      end else begin
        model(depth, tie0, exp_v, cyc, lat, to, mt);
        run_vec($sformatf("rand%0d", r), depth, tie0, probe, exp_v,
                cyc, lat, to, mt, -1);
        last_lat = lat;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/delay_latency_probe.md
Name: delay_latency_probe

Overview:
- Stimulus/measurement end of the team's N-stage delay-trigger pipelines.
- On a start request, it first flushes the downstream pipeline with zeros.
- It then injects a single-cycle nonzero probe word and counts cycles until that word appears at the pipeline output.
- It reports the measured latency and a pass/fail against the expected depth. It is used in self-checking benches and in bring-up logic.

Parameters:
- W, 3, data width of the probe word and of the pipeline interface.
- CNT_W, 5, width of the latency counter and of the latency/expected fields.
- MAX_LAT, 15, highest latency measured before timeout. Must be less than 2^CNT_W - 1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a measurement. Ignored unless state is IDLE.
- probe_val  input  W  probe word, captured at the accepted start.
- expected  input  CNT_W  expected latency, captured at the accepted start.
- pipe_in  output  W  registered drive into the pipeline under test (its D).
- pipe_out  input  W  pipeline output (its Q).
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when a measurement completes.
- latency  output  CNT_W  measured latency. Held until the next accepted start.
- timeout  output  1  set if no match occurred by MAX_LAT. Held until the next accepted start.
- match  output  1  equals (!timeout && latency == expected). Held until the next accepted start.

Behaviour:
- Reset (async, reset=0):
  - state goes to IDLE.
  - pipe_in, busy, done, latency, timeout, match, the counter, probe_reg and exp_reg all go to 0.
  - Reset mid-measurement aborts immediately. No done pulse is produced for the aborted run.
- State IDLE:
  - pipe_in=0.
  - A start with probe_val!=0 is accepted: probe_reg<=probe_val, exp_reg<=expected, latency/timeout/match<=0, cnt<=0, go to FLUSH.
  - A start with probe_val==0 is ignored: state stays IDLE and no outputs change.
- State FLUSH:
  - pipe_in=0 for exactly MAX_LAT+1 cycles (cnt counts 0..MAX_LAT), then go to SEND with cnt<=0.
  - Guarantees no stale probe is present in the pipeline.
- State SEND (exactly one cycle):
  - pipe_in=probe_reg, cnt=0.
  - Compare pipe_out==probe_reg combinationally. If equal at the edge ending this cycle, the result is latency 0: go to DONE.
  - Otherwise cnt<=1 and go to WAIT.
- State WAIT:
  - pipe_in=0.
  - At each edge: if pipe_out==probe_reg, latency<=cnt and go to DONE.
  - Otherwise, if cnt==MAX_LAT, latency<=MAX_LAT, timeout<=1 and go to DONE.
  - Otherwise cnt<=cnt+1.
- Latency definition:
  - L means pipe_out equals the probe in the L-th cycle after the cycle in which pipe_in equals the probe.
  - A 3-stage DFF chain gives L=3. A direct wire gives L=0.
- State DONE (one cycle):
  - done=1, match valid, pipe_in=0.
  - Next state is IDLE. A start during DONE is ignored.
- Output timing: all outputs are registered; none depend combinationally on inputs.
- Counter: saturates at MAX_LAT and never wraps.
- Start while busy: ignored; probe_reg and exp_reg are unchanged.
- Total run time for a match at L: (MAX_LAT+1) + 1 + L cycles, plus 1 cycle of DONE.

Test Plan:
- 3-stage DFF chain (W=3), probe_val=3'd5, expected=3 → done pulses once, latency=3, timeout=0, match=1. pipe_in is 5 for exactly one cycle, and pipe_in is never nonzero in FLUSH.
- Same chain, expected=2 → latency=3, match=0, timeout=0.
- pipe_out tied to pipe_in (wire), probe_val=7, expected=0 → latency=0, match=1, done arrives MAX_LAT+3 cycles after start.
- pipe_out tied to 0, probe_val=1 → timeout=1, latency=15, match=0, done after 1+16+1+15 cycles.
- Robustness:
  - probe_val=0 with start → busy stays 0 and there is no done.
  - Second start mid-WAIT → ignored; the result matches the first run.
- Assert reset=0 during WAIT, release, then start a new run → all outputs 0 immediately. The new run reports a correct latency=3, with no stale probe detected thanks to FLUSH.
